// File: rtl/axi_pkg.sv
// Shared definitions for the AXI read arbiter: per-side state encoding,
// fixed AR attribute constants, default IDs and the AR register layout.
package axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2
    } port_state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
    localparam logic [2:0] AXI_PROT_NONE   = 3'b000;

    localparam logic [3:0] AXI_ID_INSN = 4'd0;
    localparam logic [3:0] AXI_ID_DATA = 4'd1;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_req_t;

    // SLVERR (2'b10) and DECERR (2'b11) are the error responses.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == 2'b10) || (resp == 2'b11);
    endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI3 read address / read data channel bundle between the arbiter
// (master) and the interconnect (slave).
interface axi_read_arbiter_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_rd_port_fsm.sv
// Per-side burst tracker: IDLE -> ISSUE -> DATA -> IDLE, plus rid match.
// beat_hit is combinational so returned beats are routed with zero latency.
module axi_rd_port_fsm
    import axi_pkg::*;
#(
    parameter logic [3:0] ID = AXI_ID_INSN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       accept,
    input  logic       ar_fire,
    input  logic       rvalid,
    input  logic [3:0] rid,
    input  logic       rlast,
    output logic       idle,
    output logic       beat_hit
);

    port_state_t state;

    assign idle     = (state == ST_IDLE);
    assign beat_hit = rvalid && (rid == ID) && ((state == ST_ISSUE) || (state == ST_DATA));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) state <= ST_ISSUE;
                end
                // A fast slave may return the first beat in the AR handshake cycle.
                ST_ISSUE: begin
                    if (beat_hit && rlast)       state <= ST_IDLE;
                    else if (ar_fire || beat_hit) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (beat_hit && rlast) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Arbitrates instruction/data read bursts onto one AXI3 AR channel and
// routes R beats back by rid. Round-robin arbitration with AXI_RD_RR_EN, else D over I.
module axi_read_arbiter
    import axi_pkg::*;
#(
    parameter logic [3:0] ID_I = AXI_ID_INSN,
    parameter logic [3:0] ID_D = AXI_ID_DATA
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [7:0]  i_len,
    input  logic [2:0]  i_size,
    output logic        i_addr_ok,
    output logic        i_rvalid,
    output logic        i_rlast,
    output logic        i_rerr,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [7:0]  d_len,
    input  logic [2:0]  d_size,
    output logic        d_addr_ok,
    output logic        d_rvalid,
    output logic        d_rlast,
    output logic        d_rerr,
    output logic [31:0] d_rdata,

    axi_read_arbiter_if.master axi
);

    ar_req_t ar_q;
    ar_req_t ar_d;
    logic    ar_vld;
    logic    ar_fire;
    logic    ar_free;
    logic    i_idle, d_idle;
    logic    i_hit, d_hit;
    logic    i_elig, d_elig;
    logic    grant_i, grant_d;

    assign ar_fire = ar_vld && axi.arready;
    assign ar_free = !ar_vld || axi.arready;

    assign i_elig = !reset && i_idle && i_req && ar_free;
    assign d_elig = !reset && d_idle && d_req && ar_free;

`ifdef AXI_RD_RR_EN
    // Pointer moves only on contested grants: the loser of a conflict wins the next one.
    logic favor_d;

    assign grant_d = d_elig && (!i_elig || favor_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            favor_d <= 1'b1;
        end else if (i_elig && d_elig) begin
            favor_d <= !grant_d;
        end
    end
`else
    assign grant_d = d_elig;
`endif

    assign grant_i = i_elig && !grant_d;

    always_comb begin
        ar_d = '{id: ID_I, addr: i_addr, len: i_len, size: i_size};
        if (grant_d) ar_d = '{id: ID_D, addr: d_addr, len: d_len, size: d_size};
    end

    // A grant in the handshake cycle refills the register with no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_q   <= '0;
            ar_vld <= 1'b0;
        end else if (grant_i || grant_d) begin
            ar_q   <= ar_d;
            ar_vld <= 1'b1;
        end else if (ar_fire) begin
            ar_vld <= 1'b0;
        end
    end

    axi_rd_port_fsm #(.ID(ID_I)) u_i_fsm (
        .clk      (clk),
        .reset    (reset),
        .accept   (grant_i),
        .ar_fire  (ar_fire && (ar_q.id == ID_I)),
        .rvalid   (axi.rvalid),
        .rid      (axi.rid),
        .rlast    (axi.rlast),
        .idle     (i_idle),
        .beat_hit (i_hit)
    );

    axi_rd_port_fsm #(.ID(ID_D)) u_d_fsm (
        .clk      (clk),
        .reset    (reset),
        .accept   (grant_d),
        .ar_fire  (ar_fire && (ar_q.id == ID_D)),
        .rvalid   (axi.rvalid),
        .rid      (axi.rid),
        .rlast    (axi.rlast),
        .idle     (d_idle),
        .beat_hit (d_hit)
    );

    assign i_addr_ok = grant_i;
    assign d_addr_ok = grant_d;

    assign axi.arid    = ar_q.id;
    assign axi.araddr  = ar_q.addr;
    assign axi.arlen   = ar_q.len;
    assign axi.arsize  = ar_q.size;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = AXI_LOCK_NORMAL;
    assign axi.arcache = AXI_CACHE_NONE;
    assign axi.arprot  = AXI_PROT_NONE;
    assign axi.arvalid = ar_vld;
    assign axi.rready  = !reset;

    assign i_rvalid = i_hit;
    assign i_rlast  = i_hit && axi.rlast;
    assign i_rerr   = i_hit && resp_is_err(axi.rresp);
    assign i_rdata  = i_hit ? axi.rdata : '0;

    assign d_rvalid = d_hit;
    assign d_rlast  = d_hit && axi.rlast;
    assign d_rerr   = d_hit && resp_is_err(axi.rresp);
    assign d_rdata  = d_hit ? axi.rdata : '0;

endmodule
